pc_register_unit: RTL

- Registered, parametrised program counter for the 8227 core. It supersedes the combinational PC increment/decrement path.
- Holds the PC and supports hold, increment, decrement, full load, low-byte load and signed relative branch.
- Models the 6502 page-crossing branch penalty as a two-cycle high-byte fix-up handshake.
- Sits between the control-unit op decode and the address bus mux.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_branch_adder.sv | 32 +++
 rtl/pc_register_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg
// Shared types and constants for the program counter register unit.
//   pc_op_t    : PC command encoding driven by the control-unit op decode.
//   pc_state_t : branch fix-up state (IDLE / FIXUP).
//   PAGE_W     : width of a 6502 page offset (low byte of the PC).
// Optional build macro used by the unit: PC_PREV_EN (adds prev_pc trace port).
package pc_pkg;

    localparam int PAGE_W = 8;

    typedef enum logic [2:0] {
        PC_HOLD     = 3'd0,
        PC_INC      = 3'd1,
        PC_DEC      = 3'd2,
        PC_LOAD     = 3'd3,
        PC_LOAD_LOW = 3'd4,
        PC_BRANCH   = 3'd5
    } pc_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FIXUP = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_branch_adder.sv
// pc_branch_adder
// Combinational low-byte adder for relative branches. Adds the signed branch
// offset to the current page offset as an unsigned 9-bit sum and reports
// whether the result left the current page and in which direction.
// Ports:
//   pc_low     in  8  current pc[7:0]
//   offset     in  8  signed two's-complement branch offset
//   new_low    out 8  branch target low byte
//   page_cross out 1  target lies in a different page
//   dir_down   out 1  high byte must be decremented (else incremented)
module pc_branch_adder
    import pc_pkg::*;
(
    input  logic [PAGE_W-1:0] pc_low,
    input  logic [PAGE_W-1:0] offset,
    output logic [PAGE_W-1:0] new_low,
    output logic              page_cross,
    output logic              dir_down
);

    logic [PAGE_W:0] sum;

    always_comb begin
        sum     = {1'b0, pc_low} + {1'b0, offset};
        new_low = sum[PAGE_W-1:0];
        // A negative offset is a large unsigned addend: a carry out means the
        // result stayed in the page, no carry means it moved one page down.
        dir_down   = offset[PAGE_W-1];
        page_cross = offset[PAGE_W-1] ? ~sum[PAGE_W] : sum[PAGE_W];
    end

endmodule

// File: rtl/pc_register_unit.sv
// pc_register_unit
// Registered program counter for the 8227 core. Supports hold, increment,
// decrement, full load, low-byte load and signed relative branch. With
// BRANCH_FAST=0 a page-crossing branch takes a second cycle to fix the high
// byte (6502 timing) and raises busy so the control unit stalls.
// Optional build macro: PC_PREV_EN adds the prev_pc trace output.
// Ports:
//   clk        in   1       core clock
//   nrst       in   1       asynchronous active-low reset
//   op         in   3       pc_op_t command, sampled every IDLE cycle
//   load_addr  in   ADDR_W  full load value for PC_LOAD
//   load_low   in   8       byte for PC_LOAD_LOW
//   offset     in   8       signed branch offset
//   pc         out  ADDR_W  current PC
//   pc_low     out  8       pc[7:0]
//   pc_high    out  8       pc[15:8]
//   busy       out  1       high-byte fix-up pending, stall
//   page_cross out  1       one-cycle pulse when a branch crosses a page
//   prev_pc    out  ADDR_W  (PC_PREV_EN only) pc value before the last change
module pc_register_unit
    import pc_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter logic [15:0] RESET_PC    = 16'hFFFC,
    parameter bit          BRANCH_FAST = 1'b0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_low,
    input  logic [7:0]        offset,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        pc_low,
    output logic [7:0]        pc_high,
    output logic              busy,
`ifdef PC_PREV_EN
    output logic              page_cross,
    output logic [ADDR_W-1:0] prev_pc
`else
    output logic              page_cross
`endif
);

    localparam int               HIGH_W    = ADDR_W - PAGE_W;
    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);

    pc_state_t         state;
    pc_state_t         state_next;
    logic              dir_down;
    logic              dir_down_next;
    logic [ADDR_W-1:0] pc_next;
    logic              cross_next;

    logic [PAGE_W-1:0] add_low;
    logic              add_cross;
    logic              add_down;
    logic [HIGH_W-1:0] high_fixed;
    logic [ADDR_W-1:0] offset_ext;

    pc_branch_adder u_branch_adder (
        .pc_low     (pc[PAGE_W-1:0]),
        .offset     (offset),
        .new_low    (add_low),
        .page_cross (add_cross),
        .dir_down   (add_down)
    );

    assign offset_ext = {{(ADDR_W-PAGE_W){offset[7]}}, offset};
    assign high_fixed = dir_down ? pc[ADDR_W-1:PAGE_W] - HIGH_W'(1)
                                 : pc[ADDR_W-1:PAGE_W] + HIGH_W'(1);

    assign pc_low  = pc[7:0];
    assign pc_high = pc[15:8];

    always_comb begin
        pc_next       = pc;
        state_next    = state;
        dir_down_next = dir_down;
        cross_next    = 1'b0;
        if (state == FIXUP) begin
            // op is ignored here; only the high byte moves
            pc_next    = {high_fixed, pc[PAGE_W-1:0]};
            state_next = IDLE;
        end else begin
            case (op)
                PC_INC:      pc_next = pc + ADDR_W'(1);
                PC_DEC:      pc_next = pc - ADDR_W'(1);
                PC_LOAD:     pc_next = load_addr;
                PC_LOAD_LOW: pc_next = {pc[ADDR_W-1:PAGE_W], load_low};
                PC_BRANCH: begin
                    cross_next = add_cross;
                    if (BRANCH_FAST) begin
                        pc_next = pc + offset_ext;
                    end else begin
                        pc_next = {pc[ADDR_W-1:PAGE_W], add_low};
                        if (add_cross) begin
                            state_next    = FIXUP;
                            dir_down_next = add_down;
                        end
                    end
                end
                default: pc_next = pc;  // PC_HOLD and reserved encodings
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc         <= RESET_VAL;
            state      <= IDLE;
            dir_down   <= 1'b0;
            busy       <= 1'b0;
            page_cross <= 1'b0;
        end else begin
            pc         <= pc_next;
            state      <= state_next;
            dir_down   <= dir_down_next;
            busy       <= (state_next == FIXUP);
            page_cross <= cross_next;
        end
    end

`ifdef PC_PREV_EN
    // The fix-up cycle is part of the branch, so prev_pc keeps the
    // pre-branch address across it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_pc <= RESET_VAL;
        end else if (state == IDLE && pc_next != pc) begin
            prev_pc <= pc;
        end
    end
`endif

endmodule
